// File: rtl/seven_seg_display_ctrl_pkg.sv
// Shared seven-segment constants: blank pattern and hex glyph table.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seven_seg_display_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] nib
  );
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seven_seg_hex_lut.sv
// Combinational nibble to active-low
// seven-segment glyph lookup.
module seven_seg_hex_lut
  import seven_seg_display_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// N-digit multiplexed seven-segment driver with
// prescaler, blanking, zero suppression and PWM.
module seven_seg_display_ctrl
  import seven_seg_display_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIVIDE_BY   = 17,
  parameter int BRIGHT_BITS = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_blank,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    scan_tick
);

  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NUM_DIGITS - 1);

  logic [DIVIDE_BY-1:0]    pre;
  logic                    tick;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic                    snap_lz;

  logic [NUM_DIGITS-1:0]   lz_sup;
  logic                    zrun;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    dark;
  logic [BRIGHT_BITS-1:0]  sp;
  logic                    lit;
  logic [6:0]              lut_seg;
  logic [NUM_DIGITS-1:0]   an_next;

  assign tick = &pre;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre         <= '0;
      idx         <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      snap_lz     <= 1'b0;
      scan_tick   <= 1'b0;
    end else begin
      pre       <= pre + 1'b1;
      scan_tick <= tick;
      if (tick) begin
        idx         <= (idx == LAST) ? '0 : idx + 1'b1;
        snap_digits <= digits;
        snap_dp     <= dp_in;
        snap_blank  <= blank;
        snap_lz     <= lz_blank;
      end
    end
  end

  // Suppression walks down from the top digit
  // while every nibble seen so far is zero.
  always_comb begin
    lz_sup = '0;
    zrun   = snap_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zrun      = zrun & (snap_digits[4*i +: 4] == 4'd0);
      lz_sup[i] = zrun;
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    dark    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = snap_digits[4*i +: 4];
        cur_dp  = snap_dp[i];
        dark    = snap_blank[i] | lz_sup[i];
      end
    end
  end

  seven_seg_hex_lut u_lut (
    .nibble (cur_nib),
    .seg    (lut_seg)
  );

  // Sub-period zero is held dark as dead time
  // between digits to avoid ghosting.
  assign sp  = pre[DIVIDE_BY-1 -: BRIGHT_BITS];
  assign lit = (sp != '0) && (sp <= brightness) && !dark;

  always_comb begin
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (idx == IW'(i))) begin
        an_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= dark ? SEG_BLANK : lut_seg;
      dp  <= dark | ~cur_dp;
    end
  end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Scoreboard bench for seven_seg_display_ctrl
// with 4 digits, 16-cycle slots, 2-bit brightness.
module tb_seven_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic        lz_blank = 1'b0;
  logic [1:0]  brightness = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        scan_tick;

  int checks = 0;
  int failures = 0;

  seven_seg_display_ctrl #(
    .NUM_DIGITS  (4),
    .DIVIDE_BY   (4),
    .BRIGHT_BITS (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank      (blank),
    .lz_blank   (lz_blank),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .scan_tick  (scan_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t        q[$];
  exp_t        mexp;
  exp_t        got;
  int          m_pre;
  int          m_idx;
  int          msp;
  logic        mdark;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  m_bl;
  logic        m_lz;

  // Reference model: predicts the registered outputs
  // each edge and queues them for the monitor.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pre = 0;
      m_idx = 0;
      m_dig = '0;
      m_dp  = '0;
      m_bl  = '0;
      m_lz  = 1'b0;
      q.delete();
    end else begin
      msp   = m_pre / 4;
      mdark = m_bl[m_idx] ||
              (m_lz && m_idx != 0 &&
               (m_dig >> (4 * m_idx)) == 16'd0);
      mexp.an = 4'hF;
      if (!mdark && msp != 0 && msp <= int'(brightness))
        mexp.an[m_idx] = 1'b0;
      mexp.seg  = mdark ? 7'h7F : seg_of(m_dig[4*m_idx +: 4]);
      mexp.dp   = mdark ? 1'b1 : !m_dp[m_idx];
      mexp.tick = (m_pre == 15);
      q.push_back(mexp);
      if (m_pre == 15) begin
        m_idx = (m_idx + 1) % 4;
        m_dig = digits;
        m_dp  = dp_in;
        m_bl  = blank;
        m_lz  = lz_blank;
      end
      m_pre = (m_pre + 1) % 16;
    end
  end

  always @(negedge clk) begin
    if (reset_n && q.size() > 0) begin
      mexp = q.pop_front();
      got  = {an, seg, dp, scan_tick};
      checks++;
      if (got !== mexp) begin
        failures++;
        $display("FAIL scoreboard t=%0t an/seg/dp/tick=%b/%b/%b/%b required=%b/%b/%b/%b",
                 $time, an, seg, dp, scan_tick,
                 mexp.an, mexp.seg, mexp.dp, mexp.tick);
      end
    end
  end

  int         lit_n[4];
  logic [6:0] seg_v[4];
  logic       seg_var[4];
  int         dplow_lit[4];
  int         w_ticks;
  int         w_blank;
  int         w_dplow;

  task automatic measure(input int n);
    w_ticks = 0;
    w_blank = 0;
    w_dplow = 0;
    for (int i = 0; i < 4; i++) begin
      lit_n[i] = 0;
      seg_v[i] = 7'h7F;
      seg_var[i] = 1'b0;
      dplow_lit[i] = 0;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (scan_tick) w_ticks++;
      if (seg == 7'h7F) w_blank++;
      if (!dp) w_dplow++;
      for (int i = 0; i < 4; i++) begin
        if (!an[i]) begin
          if (lit_n[i] > 0 && seg != seg_v[i]) seg_var[i] = 1'b1;
          lit_n[i]++;
          seg_v[i] = seg;
          if (!dp) dplow_lit[i]++;
        end
      end
    end
  endtask

  task automatic sync_slot();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_tick !== 1'b1 && n < 40);
    checks++;
    if (scan_tick !== 1'b1) begin
      failures++;
      $display("FAIL sync_slot scan_tick=%b required=1 within 40 cycles", scan_tick);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, seg, dp, scan_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_state an=%b seg=%b dp=%b tick=%b required 1111/1111111/1/0",
               an, seg, dp, scan_tick);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    digits = 16'h12AF;
    brightness = 2'd3;
    sync_slot();
    measure(64);
    checks++;
    if (w_ticks != 4) begin
      failures++;
      $display("FAIL scan_tick_count got=%0d required=4", w_ticks);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lit_n[i] != 12 || seg_var[i] || seg_v[i] !== exp_seg[i]) begin
        failures++;
        $display("FAIL scan_digit%0d lit=%0d seg=%b var=%b required lit=12 seg=%b",
                 i, lit_n[i], seg_v[i], seg_var[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_brightness();
    int levels [3];
    levels = '{1, 3, 0};
    for (int b = 0; b < 3; b++) begin
      brightness = 2'(levels[b]);
      sync_slot();
      measure(64);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (lit_n[i] != 4 * levels[b]) begin
          failures++;
          $display("FAIL bright%0d_digit%0d lit=%0d required=%0d",
                   levels[b], i, lit_n[i], 4 * levels[b]);
        end
      end
    end
    brightness = 2'd3;
  endtask

  task automatic test_lz();
    digits = 16'h0050;
    lz_blank = 1'b1;
    sync_slot();
    measure(64);
    checks++;
    if (lit_n[3] != 0 || lit_n[2] != 0 || lit_n[1] != 12 || lit_n[0] != 12) begin
      failures++;
      $display("FAIL lz_0050_lit got=%0d/%0d/%0d/%0d required=0/0/12/12",
               lit_n[3], lit_n[2], lit_n[1], lit_n[0]);
    end
    checks++;
    if (seg_v[1] !== 7'b0010010 || seg_v[0] !== 7'b1000000 || w_blank != 32) begin
      failures++;
      $display("FAIL lz_0050_seg d1=%b d0=%b blank_cycles=%0d required 0010010/1000000/32",
               seg_v[1], seg_v[0], w_blank);
    end
    digits = 16'h0000;
    sync_slot();
    measure(64);
    checks++;
    if (lit_n[3] != 0 || lit_n[2] != 0 || lit_n[1] != 0 ||
        lit_n[0] != 12 || seg_v[0] !== 7'b1000000 || w_blank != 48) begin
      failures++;
      $display("FAIL lz_zero lit=%0d/%0d/%0d/%0d seg0=%b blank=%0d required 0/0/0/12 1000000 48",
               lit_n[3], lit_n[2], lit_n[1], lit_n[0], seg_v[0], w_blank);
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_blank_dp();
    digits = 16'h12AF;
    blank = 4'b0010;
    dp_in = 4'b0100;
    sync_slot();
    measure(64);
    checks++;
    if (lit_n[3] != 12 || lit_n[2] != 12 || lit_n[1] != 0 || lit_n[0] != 12) begin
      failures++;
      $display("FAIL blank_lit got=%0d/%0d/%0d/%0d required=12/12/0/12",
               lit_n[3], lit_n[2], lit_n[1], lit_n[0]);
    end
    checks++;
    if (dplow_lit[2] != 12 || dplow_lit[0] != 0 ||
        dplow_lit[3] != 0 || w_dplow != 16) begin
      failures++;
      $display("FAIL dp_pattern lit2=%0d lit0=%0d lit3=%0d total=%0d required 12/0/0/16",
               dplow_lit[2], dplow_lit[0], dplow_lit[3], w_dplow);
    end
    blank = '0;
    dp_in = '0;
  endtask

  task automatic test_snapshot();
    int n;
    int ticks;
    int old_n;
    int new_n;
    int bad;
    digits = 16'h12AF;
    sync_slot();
    n = 0;
    while (!(m_idx == 2 && m_pre == 8) && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(m_idx == 2 && m_pre == 8)) begin
      failures++;
      $display("FAIL snapshot_sync idx=%0d pre=%0d required 2/8", m_idx, m_pre);
    end
    digits = 16'h19AF;
    ticks = 0;
    old_n = 0;
    new_n = 0;
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (scan_tick) ticks++;
      if (an == 4'b1011) begin
        if (ticks < 4 && seg == 7'b0100100) old_n++;
        else if (ticks >= 4 && seg == 7'b0010000) new_n++;
        else bad++;
      end
    end
    checks++;
    if (old_n == 0 || new_n != 12 || bad != 0) begin
      failures++;
      $display("FAIL snapshot old=%0d new=%0d bad=%0d required old>0 new=12 bad=0",
               old_n, new_n, bad);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int first_lit;
    int first_tick;
    logic [3:0] first_an;
    digits = 16'h12AF;
    brightness = 2'd3;
    n = 0;
    while (!(m_idx == 2 && m_pre == 6) && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (an !== 4'b1011) begin
      failures++;
      $display("FAIL reset_mid_pre an=%b required=1011", an);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, scan_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_async an=%b seg=%b dp=%b tick=%b required 1111/1111111/1/0",
               an, seg, dp, scan_tick);
    end
    @(negedge clk);
    reset_n = 1'b1;
    first_lit = 0;
    first_tick = 0;
    first_an = 4'hF;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (first_lit == 0 && an != 4'hF) begin
        first_lit = k;
        first_an = an;
      end
      if (first_tick == 0 && scan_tick) first_tick = k;
    end
    checks++;
    if (first_an !== 4'b1110) begin
      failures++;
      $display("FAIL reset_mid_first_digit an=%b at cycle %0d required=1110",
               first_an, first_lit);
    end
    checks++;
    if (first_tick != 16) begin
      failures++;
      $display("FAIL reset_mid_slot_len first_tick=%0d required=16", first_tick);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_lz();
    test_blank_dp();
    test_snapshot();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
